iterative_divider: RTL and testbench

//   Multi-cycle radix-2 restoring divider for the ARM execute stage.
//   It is the inverse companion to the pipelined multiplier.

---
 rtl/iterative_divider.sv | 161 ++++++++++++++++
 tb/tb_iterative_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, then a sign-fix cycle.
// Handles signed (truncate toward zero) and unsigned operands, plus divide-by-zero.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_orig;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz_pend;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH-1:0] w_p_sub;
  logic             w_ge;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  // The shifted partial remainder carries one extra bit so the compare never loses a carry;
  // after a restore step the value is below the divisor, so WIDTH bits suffice for storage.
  always_comb begin
    w_p_shift = {r_p, r_a[WIDTH-1]};
    w_ge      = (w_p_shift >= {1'b0, r_d});
    w_p_sub   = w_p_shift[WIDTH-1:0] - r_d;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and shift/subtract iterations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_p       <= '0;
      r_d       <= '0;
      r_orig    <= '0;
      r_cnt     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= f_abs(dividend, is_signed);
            r_d       <= f_abs(divisor, is_signed);
            r_orig    <= dividend;
            r_q_neg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg   <= is_signed & dividend[WIDTH-1];
            r_dz_pend <= (divisor == '0);
            r_p       <= '0;
            r_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_p   <= w_ge ? w_p_sub : w_p_shift[WIDTH-1:0];
          r_a   <= {r_a[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers; a zero divisor overrides any sign correction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        if (r_dz_pend) begin
          r_quotient  <= '1;
          r_remainder <= r_orig;
        end else begin
          r_quotient  <= r_q_neg ? f_neg(r_a) : r_a;
          r_remainder <= r_r_neg ? f_neg(r_p) : r_p;
        end
        r_div_by_zero <= r_dz_pend;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed corner cases plus random
// signed/unsigned operands checked against plain-arithmetic reference results.
module tb_iterative_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           e0;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  iterative_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: division defined by 64-bit arithmetic, truncating toward zero.
  task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint na, nb, qq, rr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      qq = na / nb;
      rr = na % nb;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
      dz = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("latency_edges", cyc - e.e0, 32'd33);
        check("busy_low_in_done", busy, 1'b0);
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic was_done);
    int   n;
    exp_t e;
    n = 0;
    was_done = 1'b0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL issue_timeout: busy=%0d after %0d cycles, required 0", busy, n);
    end else begin
      was_done  = done;
      start     = 1'b1;
      is_signed = s;
      dividend  = a;
      divisor   = b;
      ref_div(s, a, b, e.q, e.r, e.dz);
      e.e0 = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      is_signed = ~s;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", sb.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'h0000_0001;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, sb=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic wd;
    int   bad;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", div_by_zero, 1'b0);
    rst = 1'b0;

    // Unsigned 100 / 7 with busy held for the whole operation
    issue(1'b0, 32'd100, 32'd7, wd);
    bad = 0;
    repeat (32) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("busy_throughout", bad, 32'd0);
    drain();
    check("u100_7_q", quotient, 32'd14);
    check("u100_7_r", remainder, 32'd2);

    issue(1'b1, -32'sd100, 32'sd7, wd);
    drain();
    check("sm100_7_q", quotient, 32'hFFFF_FFF2);
    check("sm100_7_r", remainder, 32'hFFFF_FFFE);
    issue(1'b1, 32'sd100, -32'sd7, wd);
    drain();
    check("s100_m7_q", quotient, 32'hFFFF_FFF2);
    check("s100_m7_r", remainder, 32'd2);

    issue(1'b1, 32'h8000_0005, 32'd0, wd);
    drain();
    check("dz_q", quotient, 32'hFFFF_FFFF);
    check("dz_r", remainder, 32'h8000_0005);
    check("dz_flag", div_by_zero, 1'b1);
    issue(1'b0, 32'd10, 32'd3, wd);
    drain();
    check("dz_cleared", div_by_zero, 1'b0);

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, wd);
    drain();
    check("ovf_q", quotient, 32'h8000_0000);
    check("ovf_r", remainder, 32'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, wd);
    drain();
    check("umax_q", quotient, 32'hFFFF_FFFF);

    // Start while busy must be ignored
    issue(1'b0, 32'd1000, 32'd10, wd);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd5; divisor = 32'd1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start_q", quotient, 32'd100);

    // Back-to-back: second start lands in the done cycle
    issue(1'b0, 32'd50, 32'd5, wd);
    issue(1'b0, 32'd77, 32'd7, wd);
    check("b2b_in_done_cycle", wd, 1'b1);
    drain();

    // Asynchronous reset in the middle of RUN
    issue(1'b0, 32'd12345, 32'd67, wd);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_dz", div_by_zero, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b1, -32'sd77, 32'sd5, wd);
    drain();
    check("post_rst_q", quotient, 32'hFFFF_FFF1);
    check("post_rst_r", remainder, 32'hFFFF_FFFE);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick(), wd);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
